// File: rtl/sobel_window_gen.sv
// 3x3 pixel window generator for a Sobel stage: two line buffers feed a register window.
// Optional SOBEL_WIN_FRAME_SYNC_EN adds in_sof to restart the position counters.
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
`ifdef SOBEL_WIN_FRAME_SYNC_EN
    input  logic       in_sof,
`endif
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col, col_eff, col_nxt;
    logic [RW-1:0] row, row_eff, row_nxt;
    logic          col_last, row_last, in_image;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    win [9];

    // Position of the pixel on in_data; a frame-sync pixel is forced to (0,0).
    always_comb begin
        col_eff = col;
        row_eff = row;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
        if (in_sof) begin
            col_eff = '0;
            row_eff = '0;
        end
`endif
    end

    assign col_last = (col_eff == COL_LAST);
    assign row_last = (row_eff == ROW_LAST);
    assign in_image = (row_eff >= RW'(2)) && (col_eff >= CW'(2));

    always_comb begin
        col_nxt = col_eff + CW'(1);
        row_nxt = row_eff;
        if (col_last) begin
            col_nxt = '0;
            row_nxt = row_last ? '0 : row_eff + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            out_valid <= in_valid && in_image;
            out_sof   <= in_valid && in_image && (row_eff == RW'(2)) && (col_eff == CW'(2));
            out_eol   <= in_valid && in_image && col_last;
            out_eof   <= in_valid && in_image && col_last && row_last;
            if (in_valid) begin
                col    <= col_nxt;
                row    <= row_nxt;
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb1[col_eff];
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb0[col_eff];
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= in_data;
            end
        end
    end

    // Line buffers carry no reset: rows 0 and 1 overwrite them before any valid window.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[col_eff] <= lb0[col_eff];
            lb0[col_eff] <= in_data;
        end
    end

    assign p0 = win[0];
    assign p1 = win[1];
    assign p2 = win[2];
    assign p3 = win[3];
    assign p4 = win[4];
    assign p5 = win[5];
    assign p6 = win[6];
    assign p7 = win[7];
    assign p8 = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: expected windows come from a pixel-value model.
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int OW = 75;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
    logic       in_sof = 1'b0;
`endif
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       out_valid, out_sof, out_eol, out_eof;
    logic [OW-1:0] got;

    logic [OW-1:0] exp_q[$];
    logic [71:0]   last_win = '0;
    bit            hold_ok = 1'b1;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cnt_valid, cnt_eol, cnt_eof, cnt_sof;

    sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef SOBEL_WIN_FRAME_SYNC_EN
        .in_sof(in_sof),
`endif
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    assign got = {out_sof, out_eol, out_eof, p0, p1, p2, p3, p4, p5, p6, p7, p8};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return base + 8'(r * 16 + c);
    endfunction

    function automatic logic [OW-1:0] exp_win(input logic [7:0] base, input int r, input int c);
        logic [71:0] w;
        logic        sof, eol, eof;
        w = {pix(base, r-2, c-2), pix(base, r-2, c-1), pix(base, r-2, c),
             pix(base, r-1, c-2), pix(base, r-1, c-1), pix(base, r-1, c),
             pix(base, r,   c-2), pix(base, r,   c-1), pix(base, r,   c)};
        sof = (r == 2) && (c == 2);
        eol = (c == W - 1);
        eof = (r == H - 1) && (c == W - 1);
        return {sof, eol, eof, w};
    endfunction

    // One clock: drive inputs, let the edge sample them, check the result 1 ns later.
    task automatic step(input bit v, input logic [7:0] d, input bit sof,
                        input bit has_exp, input logic [OW-1:0] e);
        logic [OW-1:0] e_pop;
        if (has_exp) exp_q.push_back(e);
        in_valid = v;
        in_data  = d;
`ifdef SOBEL_WIN_FRAME_SYNC_EN
        in_sof   = sof;
`else
        if (sof) $display("note: frame sync requested but not built in");
`endif
        @(posedge clk);
        #1;
        check_eq("out_valid", OW'(out_valid), OW'(has_exp));
        cnt_valid += int'(out_valid);
        cnt_sof   += int'(out_valid && out_sof);
        cnt_eol   += int'(out_valid && out_eol);
        cnt_eof   += int'(out_valid && out_eof);
        if (has_exp) begin
            e_pop = exp_q.pop_front();
            check_eq("window", got, e_pop);
            last_win = e_pop[71:0];
            hold_ok  = 1'b1;
        end else begin
            check_eq("flags_idle", OW'({out_sof, out_eol, out_eof}), '0);
            if (!v && hold_ok) check_eq("hold", OW'(got[71:0]), OW'(last_win));
            if (v) hold_ok = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gaps, input int npix,
                              input bit sof_first);
        int r, c;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            if (gaps && $urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, '0);
            step(1'b1, pix(base, r, c), sof_first && (i == 0),
                 (r >= 2) && (c >= 2), exp_win(base, r, c));
        end
        in_valid = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_valid = 0;
        cnt_sof   = 0;
        cnt_eol   = 0;
        cnt_eof   = 0;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_nvalid"}, OW'(cnt_valid), OW'((W - 2) * (H - 2)));
        check_eq({tag, "_nsof"},   OW'(cnt_sof),   OW'(1));
        check_eq({tag, "_neol"},   OW'(cnt_eol),   OW'(H - 2));
        check_eq({tag, "_neof"},   OW'(cnt_eof),   OW'(1));
    endtask

    initial begin
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", got, '0);
        check_eq("reset_valid", OW'(out_valid), '0);
        @(negedge clk);
        rst = 1'b1;

        // Continuous stream, then the same stream with random gaps.
        clear_counts();
        send_frame(8'h00, 1'b0, W * H, 1'b0);
        check_counts("contig");
        clear_counts();
        send_frame(8'h00, 1'b1, W * H, 1'b0);
        check_counts("gaps");
        repeat (3) step(1'b0, 8'hee, 1'b0, 1'b0, '0);

        // Back-to-back frames, second offset by 0x80.
        clear_counts();
        send_frame(8'h00, 1'b0, W * H, 1'b0);
        send_frame(8'h80, 1'b0, W * H, 1'b0);
        check_eq("b2b_nvalid", OW'(cnt_valid), OW'(2 * (W - 2) * (H - 2)));
        check_eq("b2b_nsof", OW'(cnt_sof), OW'(2));

        // Reset in the middle of row 2 after one window has been produced.
        send_frame(8'h40, 1'b0, 2 * W + 3, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midreset_outputs", got, '0);
        check_eq("midreset_valid", OW'(out_valid), '0);
        last_win = '0;
        hold_ok  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_counts();
        send_frame(8'h00, 1'b0, W * H, 1'b0);
        check_counts("after_reset");

`ifdef SOBEL_WIN_FRAME_SYNC_EN
        // Partial frame, then a frame-sync pixel restarts the position counters.
        send_frame(8'h60, 1'b0, W + 2, 1'b0);
        clear_counts();
        send_frame(8'h00, 1'b0, W * H, 1'b1);
        check_counts("frame_sync");
`endif

        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, '0);
        check_eq("queue_drained", OW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
